// File: rtl/down_timer_nbit.sv
// down_timer_nbit: loadable N-bit down counter with start, hold and
// optional auto-reload. A terminal-count pulse (tc) marks each 1 -> 0/reload
// transition. busy/done are decoded from the registered state only.
//
// Handshake/control semantics: there is no valid/ready pair here. load is a
// level sampled on each rising edge and wins over everything. start is a
// one-cycle request honoured only in IDLE (count!=0) or DONE (reload!=0).
// hold and reload_en are levels sampled on each edge.
module down_timer_nbit #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         start,
  input  logic         hold,
  input  logic         reload_en,
  output logic [W-1:0] count,
  output logic         tc,
  output logic         busy,
  output logic         done,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t       state, state_n;
  logic [W-1:0] count_n;
  logic [W-1:0] reload_reg, reload_n;
  logic         tc_n;

  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] ZERO = '0;

  // State, count, reload value and tc registers; reset clears everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      count      <= ZERO;
      reload_reg <= ZERO;
      tc         <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      reload_reg <= reload_n;
      tc         <= tc_n;
    end
  end

  // Next-state and next-datapath decode; load overrides every state.
  always_comb begin
    state_n  = state;
    count_n  = count;
    reload_n = reload_reg;
    tc_n     = 1'b0;
    if (load) begin
      count_n  = load_val;
      reload_n = load_val;
      state_n  = IDLE;
    end else begin
      case (state)
        IDLE: begin
          // Entering RUN does not decrement on the same edge.
          if (start && (count != ZERO)) state_n = RUN;
        end
        RUN: begin
          if (hold) begin
            state_n = HOLD;
          end else if (count == ONE) begin
            tc_n = 1'b1;
            if (reload_en) begin
              count_n = reload_reg;
            end else begin
              count_n = ZERO;
              state_n = DONE;
            end
          end else if (count == ZERO) begin
            // Unreachable in normal use; stop cleanly without a tc pulse.
            state_n = DONE;
          end else begin
            count_n = count - ONE;
          end
        end
        HOLD: begin
          // Resume costs one cycle: no decrement on the release edge.
          if (!hold) state_n = RUN;
        end
        DONE: begin
          if (start && (reload_reg != ZERO)) begin
            count_n = reload_reg;
            state_n = RUN;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Status outputs decoded purely from the registered state.
  always_comb begin
    busy      = (state == RUN) || (state == HOLD);
    done      = (state == DONE);
    state_dbg = state;
  end

endmodule

// File: tb/tb_down_timer_nbit.sv
// tb_down_timer_nbit: directed scenarios for down_timer_nbit with W=8.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_down_timer_nbit;

  localparam int W = 8;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic         clk;
  logic         rst;
  logic         load;
  logic [W-1:0] load_val;
  logic         start;
  logic         hold;
  logic         reload_en;
  logic [W-1:0] count;
  logic         tc;
  logic         busy;
  logic         done;
  logic [1:0]   state_dbg;

  int checks;
  int errors;

  down_timer_nbit #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_val  (load_val),
    .start     (start),
    .hold      (hold),
    .reload_en (reload_en),
    .count     (count),
    .tc        (tc),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load a value and leave load low again.
  task automatic do_load(input logic [W-1:0] v);
    load     = 1'b1;
    load_val = v;
    tick();
    load     = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; load = 0; load_val = '0; start = 0; hold = 0; reload_en = 0;
    #2;
    checks++;
    if (count !== 8'd0 || tc !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || state_dbg !== S_IDLE) begin
      errors++;
      $display("FAIL reset_outputs got count=%0d tc=%b busy=%b done=%b st=%0d exp 0 0 0 0 0",
               count, tc, busy, done, state_dbg);
    end
    tick(); tick();
    rst = 1'b1;
    tick();
    checks++;
    if (count !== 8'd0 || state_dbg !== S_IDLE) begin
      errors++;
      $display("FAIL reset_release got count=%0d st=%0d exp 0 0", count, state_dbg);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] exp_c [3] = '{8'd2, 8'd1, 8'd0};
    logic         exp_t [3] = '{1'b0, 1'b0, 1'b1};
    logic         exp_d [3] = '{1'b0, 1'b0, 1'b1};
    do_load(8'd3);
    checks++;
    if (count !== 8'd3 || busy !== 1'b0 || state_dbg !== S_IDLE) begin
      errors++;
      $display("FAIL basic_load got count=%0d busy=%b st=%0d exp 3 0 0", count, busy, state_dbg);
    end
    do_start();
    checks++;
    if (count !== 8'd3 || busy !== 1'b1 || tc !== 1'b0) begin
      errors++;
      $display("FAIL basic_start got count=%0d busy=%b tc=%b exp 3 1 0", count, busy, tc);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (count !== exp_c[i] || tc !== exp_t[i] || done !== exp_d[i]) begin
        errors++;
        $display("FAIL basic_step%0d got count=%0d tc=%b done=%b exp %0d %b %b",
                 i, count, tc, done, exp_c[i], exp_t[i], exp_d[i]);
      end
    end
    tick();
    checks++;
    if (count !== 8'd0 || tc !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_after got count=%0d tc=%b done=%b busy=%b exp 0 0 1 0", count, tc, done, busy);
    end
    // start from DONE restarts from the reload value
    do_start();
    checks++;
    if (count !== 8'd3 || state_dbg !== S_RUN || done !== 1'b0) begin
      errors++;
      $display("FAIL done_restart got count=%0d st=%0d done=%b exp 3 1 0", count, state_dbg, done);
    end
    tick();
    checks++;
    if (count !== 8'd2) begin
      errors++;
      $display("FAIL done_restart_dec got count=%0d exp 2", count);
    end
    do_load(8'd0);
  endtask

  task automatic test_reload();
    logic [W-1:0] exp_c [6] = '{8'd1, 8'd2, 8'd1, 8'd2, 8'd1, 8'd2};
    logic         exp_t [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    reload_en = 1'b1;
    do_load(8'd2);
    do_start();
    checks++;
    if (count !== 8'd2 || tc !== 1'b0) begin
      errors++;
      $display("FAIL reload_start got count=%0d tc=%b exp 2 0", count, tc);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (count !== exp_c[i] || tc !== exp_t[i] || done !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL reload_step%0d got count=%0d tc=%b done=%b busy=%b exp %0d %b 0 1",
                 i, count, tc, done, busy, exp_c[i], exp_t[i]);
      end
    end
    // reload value of 1: tc every cycle
    do_load(8'd1);
    do_start();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (count !== 8'd1 || tc !== 1'b1 || state_dbg !== S_RUN) begin
        errors++;
        $display("FAIL reload1_step%0d got count=%0d tc=%b st=%0d exp 1 1 1", i, count, tc, state_dbg);
      end
    end
    reload_en = 1'b0;
    do_load(8'd0);
  endtask

  task automatic test_hold();
    logic [W-1:0] exp_c [6] = '{8'd5, 8'd5, 8'd5, 8'd5, 8'd4, 8'd3};
    logic [1:0]   exp_s [6] = '{S_HOLD, S_HOLD, S_HOLD, S_RUN, S_RUN, S_RUN};
    do_load(8'd8);
    do_start();
    tick(); tick(); tick();
    checks++;
    if (count !== 8'd5) begin
      errors++;
      $display("FAIL hold_reach got count=%0d exp 5", count);
    end
    for (int i = 0; i < 6; i++) begin
      hold  = (i < 3);
      start = (i == 1);   // must be ignored while holding
      tick();
      checks++;
      if (count !== exp_c[i] || state_dbg !== exp_s[i] || busy !== 1'b1 || tc !== 1'b0) begin
        errors++;
        $display("FAIL hold_step%0d got count=%0d st=%0d busy=%b tc=%b exp %0d %0d 1 0",
                 i, count, state_dbg, busy, tc, exp_c[i], exp_s[i]);
      end
    end
    hold = 1'b0; start = 1'b0;
    do_load(8'd0);
  endtask

  task automatic test_zero();
    do_load(8'd0);
    do_start();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (count !== 8'd0 || tc !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || state_dbg !== S_IDLE) begin
        errors++;
        $display("FAIL zero_%0d got count=%0d tc=%b busy=%b done=%b st=%0d exp 0 0 0 0 0",
                 i, count, tc, busy, done, state_dbg);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_load(8'd8);
    do_start();
    tick(); tick(); tick(); tick();
    checks++;
    if (count !== 8'd4 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_reach got count=%0d busy=%b exp 4 1", count, busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (count !== 8'd0 || busy !== 1'b0 || tc !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async got count=%0d busy=%b tc=%b exp 0 0 0", count, busy, tc);
    end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start = (i == 1);   // count is 0: ignored
      tick();
      checks++;
      if (count !== 8'd0 || tc !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || state_dbg !== S_IDLE) begin
        errors++;
        $display("FAIL rstmid_after%0d got count=%0d tc=%b busy=%b done=%b st=%0d exp 0 0 0 0 0",
                 i, count, tc, busy, done, state_dbg);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_load_priority();
    int tcs;
    do_load(8'd8);
    do_start();
    tick(); tick();
    checks++;
    if (count !== 8'd6) begin
      errors++;
      $display("FAIL ldpri_reach got count=%0d exp 6", count);
    end
    start = 1'b1; hold = 1'b1;   // load must win over both
    do_load(8'd9);
    start = 1'b0; hold = 1'b0;
    checks++;
    if (count !== 8'd9 || state_dbg !== S_IDLE || busy !== 1'b0 || tc !== 1'b0) begin
      errors++;
      $display("FAIL ldpri_load got count=%0d st=%0d busy=%b tc=%b exp 9 0 0 0", count, state_dbg, busy, tc);
    end
    do_start();
    tcs = 0;
    for (int i = 8; i >= 0; i--) begin
      tick();
      if (tc === 1'b1) tcs++;
      checks++;
      if (count !== 8'(i)) begin
        errors++;
        $display("FAIL ldpri_step got count=%0d exp %0d", count, i);
      end
    end
    tick();
    if (tc === 1'b1) tcs++;
    checks++;
    if (tcs != 1 || done !== 1'b1) begin
      errors++;
      $display("FAIL ldpri_tc got tc_pulses=%0d done=%b exp 1 1", tcs, done);
    end
  endtask

  task automatic test_full_range();
    int tcs;
    int bad;
    do_load(8'hFF);
    do_start();
    tcs = 0;
    bad = 0;
    for (int i = 254; i >= 0; i--) begin
      tick();
      if (count !== 8'(i)) bad++;
      if (tc !== (i == 0)) bad++;
      if (tc === 1'b1) tcs++;
    end
    checks++;
    if (bad != 0 || tcs != 1 || done !== 1'b1 || count !== 8'd0) begin
      errors++;
      $display("FAIL full_range got bad_samples=%0d tc_pulses=%0d done=%b count=%0d exp 0 1 1 0",
               bad, tcs, done, count);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_reload();
    test_hold();
    test_zero();
    test_reset_mid();
    test_load_priority();
    test_full_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/down_timer_nbit.md
DOWN_TIMER_NBIT -- requirements
Module: down_timer_nbit

Interface
REQ-001 Parameter: W, default 8, count width in bits; legal range W >= 2.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 load  input  1  when high, captures load_val into count and the reload register.
REQ-005 load_val  input  W  initial and reload value.
REQ-006 start  input  1  single-cycle request to begin counting down.
REQ-007 hold  input  1  level; pauses counting while high.
REQ-008 reload_en  input  1  level; on terminal count, reload and keep running instead of stopping.
REQ-009 count  output  W  registered current count value.
REQ-010 tc  output  1  registered terminal-count pulse, exactly one cycle wide.
REQ-011 busy  output  1  high in states RUN and HOLD.
REQ-012 done  output  1  high in state DONE.

Function
REQ-013 The FSM SHALL have four states, IDLE, RUN, HOLD and DONE; the state encoding is internal.
REQ-014 load SHALL take priority over every other input in every state: count <= load_val, reload_reg <= load_val, state <= IDLE, tc <= 0.
REQ-015 IDLE: start=1 with count!=0 SHALL move to RUN with no decrement on that edge; start with count==0 SHALL be ignored.
REQ-016 RUN with hold=0 and count>1: count SHALL decrement by 1 per edge.
REQ-017 RUN with hold=0, count==1, reload_en=0: count <= 0, state <= DONE, tc <= 1.
REQ-018 RUN with hold=0, count==1, reload_en=1: count <= reload_reg, state stays RUN, tc <= 1.
REQ-019 With reload_reg==1 and reload_en=1, tc SHALL be high on every cycle while in RUN.
REQ-020 RUN with hold=1: count SHALL be frozen and state <= HOLD.
REQ-021 HOLD with hold=1: count SHALL be frozen.
REQ-022 HOLD with hold=0: state <= RUN with no decrement on that edge (one-cycle resume latency).
REQ-023 DONE: start=1 with reload_reg!=0 SHALL set count <= reload_reg and state <= RUN; start with reload_reg==0 SHALL be ignored.
REQ-024 start SHALL be ignored in RUN and HOLD.
REQ-025 tc SHALL be 0 on every edge not covered by REQ-017/REQ-018.
REQ-026 count SHALL never wrap below 0; decrement arithmetic is W bits, unsigned.
REQ-027 A load_val of 2^W-1 SHALL count the full range down without overflow.
REQ-028 busy and done SHALL be decoded from the registered state only, with no combinational path from the inputs.

Reset
REQ-029 While rst=0, outputs SHALL take these values immediately and asynchronously: count=0, tc=0, busy=0, done=0; reload_reg=0 and state=IDLE.
REQ-030 The first rising clk edge after rst returns high SHALL be processed normally.
REQ-031 Reset asserted mid-operation SHALL abort the count, with no tc pulse generated.

Verification (W=8)
REQ-032 load_val=3, pulse load, then pulse start.
- Response: count 3,3,2,1,0.
- tc is high for exactly the one cycle in which count=0.
- done=1 and busy=0 thereafter.
REQ-033 reload_en=1, load_val=2, load, start.
- Response: count sequence 2,2,1,2,1,2,...
- tc pulses every 2 cycles.
- done never asserts.
REQ-034 Running from 8, hold=1 for 3 cycles when count=5.
- Response: count holds 5 for 4 cycles; busy=1 throughout.
- After hold falls: one further cycle at 5, then 4,3,...
REQ-035 load_val=0, load, start.
- Response: state stays IDLE, count=0, tc=0, busy=0.
REQ-036 rst driven low at count=4 in RUN.
- Response: count=0 and busy=0 before the next edge.
- After release: IDLE, no tc.
REQ-037 In RUN at count=6, pulse load with load_val=9.
- Response: IDLE with count=9; a subsequent start counts 9 down to 0 with a single tc.
